// File: rtl/pwm_ramp_pkg.sv
// Shared constants for the PWM ramp controller: register map, CTRL bit layout, widths.
package pwm_ramp_pkg;

  localparam int CW_DEFAULT = 25;
  localparam int AVS_DW     = 32;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    REG_PERIOD = 2'd0,
    REG_TARGET = 2'd1,
    REG_STEP   = 2'd2,
    REG_CTRL   = 2'd3
  } reg_addr_e;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_BUSY      = 1;
  localparam int CTRL_WDOG_TRIP = 2;

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running frame counter 0..period-1; frame_tick marks the last cycle of each frame.
module pwm_frame_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         async_reset,
  input  logic [W-1:0] period,
  output logic         frame_tick
);

  logic [W-1:0] frame_cnt;

  // >= rather than == so a counter past the end can never run away
  assign frame_tick = (frame_cnt >= period - W'(1));

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)    frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else                 frame_cnt <= frame_cnt + W'(1);
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Avalon-MM register block that slews the PWM high time toward a target once per frame.
// Optional failsafe watchdog enabled by defining PWM_RAMP_WATCHDOG_EN.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int COUNTER_WIDTH  = CW_DEFAULT,
  parameter int DEFAULT_PERIOD = 1000000
`ifdef PWM_RAMP_WATCHDOG_EN
  ,
  parameter int WDOG_FRAMES    = 50,
  parameter int SAFE_HIGH      = 75000
`endif
) (
  input  logic                     clk,
  input  logic                     async_reset,
  input  logic [1:0]               avs_address,
  input  logic                     avs_write,
  input  logic [AVS_DW-1:0]        avs_writedata,
  input  logic                     avs_read,
  output logic [AVS_DW-1:0]        avs_readdata,
  output logic [COUNTER_WIDTH:0]   divider_out,
  output logic [COUNTER_WIDTH:0]   high_time_out,
  output logic                     frame_tick,
  output logic                     busy
);

  localparam int W = COUNTER_WIDTH + 1;

  reg_addr_e    addr;
  logic [W-1:0] wd;
  logic         unused_wdata;
  logic         wr_period, wr_target, wr_step, wr_ctrl;

  assign addr         = reg_addr_e'(avs_address);
  assign wd           = avs_writedata[W-1:0];
  assign unused_wdata = ^avs_writedata[AVS_DW-1:W];
  assign wr_period    = avs_write && (addr == REG_PERIOD);
  assign wr_target    = avs_write && (addr == REG_TARGET);
  assign wr_step      = avs_write && (addr == REG_STEP);
  assign wr_ctrl      = avs_write && (addr == REG_CTRL);

  logic [W-1:0] period_reg, target_reg, step_reg;
  logic         enable, en_nxt, wdog_trip;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      period_reg <= W'(DEFAULT_PERIOD);
      step_reg   <= '0;
      enable     <= 1'b0;
    end else begin
      if (wr_period) period_reg <= (wd < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : wd;
      if (wr_step)   step_reg   <= wd;
      if (wr_ctrl)   enable     <= avs_writedata[CTRL_ENABLE];
    end
  end

`ifdef PWM_RAMP_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_FRAMES + 1);

  logic [WDW-1:0] wdog_cnt;
  logic           wdog_fire;

  // a TARGET write in the expiring frame wins over the failsafe
  assign wdog_fire = frame_tick && !wr_target && (wdog_cnt == WDW'(WDOG_FRAMES - 1));

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (wr_target) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (wdog_fire) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b1;
    end else if (frame_tick) begin
      wdog_cnt  <= wdog_cnt + WDW'(1);
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)   target_reg <= '0;
    else if (wr_target) target_reg <= wd;
    else if (wdog_fire) target_reg <= W'(SAFE_HIGH);
  end
`else
  assign wdog_trip = 1'b0;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)   target_reg <= '0;
    else if (wr_target) target_reg <= wd;
  end
`endif

  pwm_frame_timer #(.W(W)) u_timer (
    .clk         (clk),
    .async_reset (async_reset),
    .period      (divider_out),
    .frame_tick  (frame_tick)
  );

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)    divider_out <= W'(DEFAULT_PERIOD);
    else if (frame_tick) divider_out <= period_reg;
  end

  // Slew datapath: one extra bit so sums and differences never wrap
  logic [W-1:0] tgt_clamp, high_nxt;
  logic [W:0]   hi_x, tgt_x, stp_x, per_x, gap, slew;

  assign tgt_clamp = (target_reg < period_reg) ? target_reg : period_reg;

  always_comb begin
    hi_x  = {1'b0, high_time_out};
    tgt_x = {1'b0, tgt_clamp};
    stp_x = {1'b0, step_reg};
    per_x = {1'b0, period_reg};
    gap   = (tgt_x >= hi_x) ? (tgt_x - hi_x) : (hi_x - tgt_x);
    if (stp_x == '0 || stp_x >= gap) slew = tgt_x;
    else if (tgt_x > hi_x)           slew = hi_x + stp_x;
    else                             slew = hi_x - stp_x;
    // a shrinking period pulls the high time down in the same update
    high_nxt = (slew > per_x) ? period_reg : slew[W-1:0];
  end

  // disabling takes effect on the write edge, not at the frame boundary
  assign en_nxt = wr_ctrl ? avs_writedata[CTRL_ENABLE] : enable;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)    high_time_out <= '0;
    else if (!en_nxt)    high_time_out <= '0;
    else if (frame_tick) high_time_out <= enable ? high_nxt : '0;
  end

  assign busy = (high_time_out != tgt_clamp);

  logic [AVS_DW-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_PERIOD: rd_mux[W-1:0] = period_reg;
      REG_TARGET: rd_mux[W-1:0] = target_reg;
      REG_STEP:   rd_mux[W-1:0] = step_reg;
      REG_CTRL: begin
        rd_mux[CTRL_ENABLE]    = enable;
        rd_mux[CTRL_BUSY]      = busy;
        rd_mux[CTRL_WDOG_TRIP] = wdog_trip;
      end
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)  avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Random + directed scoreboard bench for pwm_ramp_ctrl (default build, no watchdog).
module tb_pwm_ramp_ctrl;

  localparam int CW = 25;
  localparam int W  = CW + 1;
  localparam int DP = 64;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic          clk = 1'b0;
  logic          async_reset = 1'b0;
  logic [1:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata, def_readdata;
  logic [CW:0]   divider_out, high_time_out, def_div, def_high;
  logic          frame_tick, busy, def_tick, def_busy;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.COUNTER_WIDTH(CW), .DEFAULT_PERIOD(DP)) u_dut (
    .clk(clk), .async_reset(async_reset), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .divider_out(divider_out),
    .high_time_out(high_time_out), .frame_tick(frame_tick), .busy(busy)
  );

  // default-parameter instance, never written: holds its reset state
  pwm_ramp_ctrl u_def (
    .clk(clk), .async_reset(async_reset), .avs_address(avs_address),
    .avs_write(1'b0), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(def_readdata), .divider_out(def_div),
    .high_time_out(def_high), .frame_tick(def_tick), .busy(def_busy)
  );

  typedef struct { longint div; longint high; bit tick; bit busy; } exp_t;
  typedef struct { longint mv; longint dv; } rd_t;
  exp_t sq[$];
  rd_t  rq[$];
  exp_t e;
  rd_t  r;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  longint m_per, m_tgt, m_step, m_div, m_high, m_cnt;
  bit     m_en;

  function automatic longint lmin(longint a, longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_busy();
    return m_high != lmin(m_tgt, m_per);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_per = DP; m_tgt = 0; m_step = 0; m_en = 0;
    m_div = DP; m_high = 0; m_cnt = 0;
  endtask

  // one bus cycle: drive, predict, push expectations
  task automatic cyc(bit rst_n, bit w, bit [1:0] a, bit [31:0] d, bit rd);
    longint wv, t, nh, ndiv, ncnt;
    bit tick, en_n;
    @(negedge clk);
    async_reset = rst_n; avs_write = w; avs_address = a;
    avs_writedata = d; avs_read = rd;
    if (rd && rst_n) begin
      case (a)
        2'd0: r.mv = m_per;
        2'd1: r.mv = m_tgt;
        2'd2: r.mv = m_step;
        default: r.mv = (longint'(m_busy()) << 1) | longint'(m_en);
      endcase
      r.dv = (a == 2'd0) ? 1000000 : 0;
      rq.push_back(r);
    end
    if (!rst_n) model_reset();
    else begin
      wv   = longint'(d) & MASK;
      tick = (m_cnt == m_div - 1);
      en_n = (w && a == 2'd3) ? d[0] : m_en;
      if (tick) begin
        t = lmin(m_tgt, m_per);
        if (m_step == 0)      nh = t;
        else if (m_high < t)  nh = m_high + lmin(m_step, t - m_high);
        else                  nh = m_high - lmin(m_step, m_high - t);
        nh = lmin(nh, m_per);
        if (!m_en) nh = 0;
        ndiv = m_per; ncnt = 0;
      end else begin
        nh = m_high; ndiv = m_div; ncnt = m_cnt + 1;
      end
      if (!en_n) nh = 0;
      if (w) begin
        case (a)
          2'd0: m_per  = (wv < 2) ? 2 : wv;
          2'd1: m_tgt  = wv;
          2'd2: m_step = wv;
          default: ;
        endcase
      end
      m_high = nh; m_div = ndiv; m_cnt = ncnt; m_en = en_n;
    end
    e.div = m_div; e.high = m_high; e.tick = (m_cnt == m_div - 1); e.busy = m_busy();
    sq.push_back(e);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 2'd0, 32'd0, 0);
  endtask
  task automatic wr(bit [1:0] a, bit [31:0] d);
    cyc(1, 1, a, d, 0);
  endtask
  task automatic rdr(bit [1:0] a);
    cyc(1, 0, a, 32'd0, 1);
  endtask
  task automatic to_tick_cycle();
    for (int g = 0; g < 5000 && m_cnt != m_div - 1; g++) idle(1);
  endtask
  task automatic frames(int n);
    for (int k = 0; k < n; k++) begin
      to_tick_cycle();
      idle(1);
    end
  endtask

  // monitor: compares every presented output cycle and every read return
  initial begin
    forever begin
      @(posedge clk); #2;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("divider_out", longint'(divider_out), e.div);
        chk("high_time_out", longint'(high_time_out), e.high);
        chk("frame_tick", longint'(frame_tick), longint'(e.tick));
        chk("busy", longint'(busy), longint'(e.busy));
        chk("def_divider_out", longint'(def_div), 1000000);
        chk("def_high_time_out", longint'(def_high), 0);
        chk("def_frame_tick", longint'(def_tick), 0);
      end
      if (avs_read && async_reset) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL readdata: read returned with no expectation queued");
        end else begin
          r = rq.pop_front();
          chk("readdata", longint'(avs_readdata), r.mv);
          chk("def_readdata", longint'(def_readdata), r.dv);
        end
      end
    end
  end

  initial begin
    bit [1:0] a;
    bit [31:0] d;
    int x;
    model_reset();
    cyc(0, 0, 2'd0, 32'd0, 0);
    cyc(0, 0, 2'd0, 32'd0, 0);
    idle(2);
    rdr(2'd0); rdr(2'd3); rdr(2'd1);

    wr(2'd0, 100); wr(2'd2, 0); wr(2'd1, 40); wr(2'd3, 1);
    frames(2); rdr(2'd1);

    wr(2'd2, 10); wr(2'd1, 0); frames(5);
    wr(2'd1, 35); frames(5); rdr(2'd3);

    wr(2'd2, 0); wr(2'd1, 80); wr(2'd0, 50); frames(2);

    wr(2'd0, 100); wr(2'd1, 20); frames(1);
    to_tick_cycle(); wr(2'd1, 60); frames(2);

    wr(2'd2, 7); idle(30); wr(2'd3, 0); idle(3); rdr(2'd3);
    wr(2'd3, 1); frames(4);

    wr(2'd0, 1); frames(1); rdr(2'd0); frames(3);
    wr(2'd0, 0); frames(2);

    wr(2'd1, 32'hFFFF_FFFF); wr(2'd2, 32'hFFFF_FFFF); wr(2'd0, 30);
    frames(2); rdr(2'd1); rdr(2'd2);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        cyc(0, 0, 2'd0, 32'd0, 0);
        cyc(0, 0, 2'd0, 32'd0, 0);
      end
      x = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0: d = $urandom_range(0, 40);
        2'd1: d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 50);
        2'd2: d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 12);
        default: d = ($urandom & 32'hFFFF_FFFE) | 32'(($urandom_range(0, 3) != 0));
      endcase
      if (x < 6)       cyc(1, 1, a, d, 0);
      else if (x < 8)  cyc(1, 1, a, d, 1);
      else if (x < 18) cyc(1, 0, a, 32'd0, 1);
      else             idle(1);
    end

    idle(5);
    cyc(0, 0, 2'd0, 32'd0, 0);
    idle(3);
    rdr(2'd0);

    @(posedge clk); #4;
    chk("scoreboard_drained", longint'(sq.size()), 0);
    chk("read_queue_drained", longint'(rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
